// File: rtl/sprite_pal_pkg.sv
// sprite_pal_pkg: shared palette defaults, flash FSM states and colour helpers
package sprite_pal_pkg;

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

    // Palette loaded into every bank at reset; entry 0 is the magenta colour key
    localparam logic [11:0] DEFAULT_PAL [16] = '{
        12'hF0F, 12'h00A, 12'h0A0, 12'hA00,
        12'h000, 12'h555, 12'hAAA, 12'h0FF,
        12'hFF0, 12'h800, 12'h080, 12'hFFF,
        12'h008, 12'h888, 12'hFB7, 12'h444
    };

    // All-ones colour for the given channel width, right-aligned in 48 bits
    function automatic logic [47:0] rgb_white(input int ch_w);
        return (48'd1 << (3 * ch_w)) - 48'd1;
    endfunction

endpackage

// File: rtl/sprite_flash_fsm.sv
// sprite_flash_fsm: frame-counted hit flash alternating ON/OFF phases
module sprite_flash_fsm
    import sprite_pal_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             flash_start,
    input  logic [LEN_W-1:0] flash_len,
    output logic             flash_on,
    output logic             flash_active
);

    flash_state_t     state;
    logic [LEN_W-1:0] cnt;

    // A valid start always restarts the flash and swallows a coincident tick
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            flash_on     <= 1'b0;
            flash_active <= 1'b0;
        end else if (flash_start && flash_len != '0) begin
            state        <= FLASH_ON;
            cnt          <= flash_len;
            flash_on     <= 1'b1;
            flash_active <= 1'b1;
        end else if (frame_tick && state != IDLE) begin
            if (cnt == LEN_W'(1)) begin
                state        <= IDLE;
                flash_on     <= 1'b0;
                flash_active <= 1'b0;
            end else begin
                cnt      <= cnt - LEN_W'(1);
                state    <= (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                flash_on <= (state == FLASH_OFF);
            end
        end
    end

endmodule

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: writable multi-palette colour lookup with hit-flash, 2-cycle latency
module sprite_palette_bank
    import sprite_pal_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int NUM_PAL = 4,
    parameter int CH_W    = 4,
    parameter int KEY_IDX = 0,
    parameter int LEN_W   = 4,
    localparam int PAL_W  = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int ENT_W  = 3 * CH_W,
    localparam int DEPTH  = 2 ** IDX_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             pix_valid,
    input  logic [PAL_W-1:0] pix_pal,
    input  logic [IDX_W-1:0] pix_idx,
    input  logic             wr_en,
    input  logic [PAL_W-1:0] wr_pal,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ENT_W-1:0] wr_rgb,
    input  logic             frame_tick,
    input  logic             flash_start,
    input  logic [LEN_W-1:0] flash_len,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_red,
    output logic [CH_W-1:0]  out_green,
    output logic [CH_W-1:0]  out_blue,
    output logic             out_transparent,
    output logic             flash_active
);

    logic [ENT_W-1:0] pal [NUM_PAL][DEPTH];
    logic [PAL_W-1:0] rd_pal;
    logic             s1_valid;
    logic             s1_trans;
    logic [ENT_W-1:0] s1_rgb;
    logic             flash_on;

    assign rd_pal = (32'(pix_pal) < NUM_PAL) ? pix_pal : '0;

    // Palette registers: reset to the defaults, one write per cycle, bad banks dropped
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int i = 0; i < DEPTH; i++)
                    pal[p][i] <= ENT_W'(DEFAULT_PAL[4'(i)]);
        end else if (wr_en && 32'(wr_pal) < NUM_PAL) begin
            pal[wr_pal][wr_idx] <= wr_rgb;
        end
    end

    // Stage 1: fetch the entry before this cycle's write lands, so collisions read old data
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_trans <= 1'b0;
            s1_rgb   <= '0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_rgb   <= pal[rd_pal][pix_idx];
                s1_trans <= (pix_idx == IDX_W'(KEY_IDX));
            end
        end
    end

    // Stage 2: whiten opaque pixels during the ON phase, hold outputs between requests
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid       <= 1'b0;
            out_red         <= '0;
            out_green       <= '0;
            out_blue        <= '0;
            out_transparent <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                {out_red, out_green, out_blue} <= (flash_on && !s1_trans) ? ENT_W'(rgb_white(CH_W)) : s1_rgb;
                out_transparent <= s1_trans;
            end
        end
    end

    sprite_flash_fsm #(.LEN_W(LEN_W)) u_flash (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .flash_start  (flash_start),
        .flash_len    (flash_len),
        .flash_on     (flash_on),
        .flash_active (flash_active)
    );

endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: directed vector table plus randomized run against a frame-phase reference model
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [1:0]  pix_pal = '0;
    logic [3:0]  pix_idx = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_pal = '0;
    logic [3:0]  wr_idx = '0;
    logic [11:0] wr_rgb = '0;
    logic        frame_tick = 1'b0;
    logic        flash_start = 1'b0;
    logic [3:0]  flash_len = '0;
    logic        out_valid;
    logic [3:0]  out_red, out_green, out_blue;
    logic        out_transparent;
    logic        flash_active;

    always #5 Clk = ~Clk;

    sprite_palette_bank dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .pix_valid       (pix_valid),
        .pix_pal         (pix_pal),
        .pix_idx         (pix_idx),
        .wr_en           (wr_en),
        .wr_pal          (wr_pal),
        .wr_idx          (wr_idx),
        .wr_rgb          (wr_rgb),
        .frame_tick      (frame_tick),
        .flash_start     (flash_start),
        .flash_len       (flash_len),
        .out_valid       (out_valid),
        .out_red         (out_red),
        .out_green       (out_green),
        .out_blue        (out_blue),
        .out_transparent (out_transparent),
        .flash_active    (flash_active)
    );

    localparam logic [11:0] DEF [16] = '{
        12'hF0F, 12'h00A, 12'h0A0, 12'hA00,
        12'h000, 12'h555, 12'hAAA, 12'h0FF,
        12'hFF0, 12'h800, 12'h080, 12'hFFF,
        12'h008, 12'h888, 12'hFB7, 12'h444
    };

    // Reference model: palette contents, one request in flight, visible outputs,
    // and the flash as "frames elapsed" fk out of fn (ON on even frames)
    logic [11:0] mem [4][16];
    bit          p_v, p_t, e_v, e_t;
    logic [11:0] p_rgb, e_rgb;
    int          fk, fn;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        bit v; logic [1:0] pal; logic [3:0] idx;
        bit we; logic [1:0] wpal; logic [3:0] widx; logic [11:0] wrgb;
        bit tick; bit fs; logic [3:0] flen;
        bit ev; logic [11:0] ergb; bit et; bit ea;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(int v, int pal, int idx, int we, int wpal, int widx, int wrgb,
                                int tick, int fs, int flen, int ev, int ergb, int et, int ea);
        vec_t r;
        r.v = v[0]; r.pal = 2'(pal); r.idx = 4'(idx);
        r.we = we[0]; r.wpal = 2'(wpal); r.widx = 4'(widx); r.wrgb = 12'(wrgb);
        r.tick = tick[0]; r.fs = fs[0]; r.flen = 4'(flen);
        r.ev = ev[0]; r.ergb = 12'(ergb); r.et = et[0]; r.ea = ea[0];
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit fl_on();
        return fk < fn && fk % 2 == 0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                mem[p][i] = DEF[i];
        p_v = 0; p_t = 0; p_rgb = '0;
        e_v = 0; e_t = 0; e_rgb = '0;
        fk = 0; fn = 0;
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (!Reset_n) model_reset();
        else begin
            e_v = p_v;
            if (p_v) begin
                e_rgb = (fl_on() && !p_t) ? 12'hFFF : p_rgb;
                e_t = p_t;
            end
            p_v = pix_valid;
            if (pix_valid) begin
                p_rgb = mem[pix_pal][pix_idx];
                p_t = (pix_idx == 4'd0);
            end
            if (wr_en) mem[wr_pal][wr_idx] = wr_rgb;
            if (flash_start && flash_len != 0) begin
                fk = 0;
                fn = int'(flash_len);
            end else if (frame_tick && fk < fn) fk++;
        end
        #1;
        check("model out_valid", out_valid, e_v);
        check("model rgb", {out_red, out_green, out_blue}, e_rgb);
        check("model out_transparent", out_transparent, e_t);
        check("model flash_active", flash_active, fk < fn);
    endtask

    task automatic idle_inputs();
        pix_valid = 0; wr_en = 0; frame_tick = 0; flash_start = 0; flash_len = '0;
    endtask

    initial begin
        model_reset();
        tbl[0]  = mk(1,0,11, 0,0,0,0,     0,0,0, 0,12'h000,0,0);
        tbl[1]  = mk(1,0,0,  0,0,0,0,     0,0,0, 1,12'hFFF,0,0);
        tbl[2]  = mk(0,0,0,  1,2,3,12'h123, 0,0,0, 1,12'hF0F,1,0);
        tbl[3]  = mk(1,2,3,  0,0,0,0,     0,0,0, 0,12'hF0F,1,0);
        tbl[4]  = mk(1,0,3,  0,0,0,0,     0,0,0, 1,12'h123,0,0);
        tbl[5]  = mk(0,0,0,  0,0,0,0,     0,0,0, 1,12'hA00,0,0);
        tbl[6]  = mk(1,1,5,  1,1,5,12'hABC, 0,0,0, 0,12'hA00,0,0);
        tbl[7]  = mk(1,1,5,  0,0,0,0,     0,0,0, 1,12'h555,0,0);
        tbl[8]  = mk(0,0,0,  0,0,0,0,     0,1,3, 1,12'hABC,0,1);
        tbl[9]  = mk(1,0,4,  0,0,0,0,     0,0,0, 0,12'hABC,0,1);
        tbl[10] = mk(1,0,0,  0,0,0,0,     0,0,0, 1,12'hFFF,0,1);
        tbl[11] = mk(1,0,4,  0,0,0,0,     1,0,0, 1,12'hF0F,1,1);
        tbl[12] = mk(1,0,4,  0,0,0,0,     0,0,0, 1,12'h000,0,1);
        tbl[13] = mk(1,0,4,  0,0,0,0,     1,0,0, 1,12'h000,0,1);
        tbl[14] = mk(1,0,4,  0,0,0,0,     0,0,0, 1,12'hFFF,0,1);
        tbl[15] = mk(1,0,0,  0,0,0,0,     1,0,0, 1,12'hFFF,0,0);
        tbl[16] = mk(1,0,4,  0,0,0,0,     0,0,0, 1,12'hF0F,1,0);
        tbl[17] = mk(0,0,0,  0,0,0,0,     0,0,0, 1,12'h000,0,0);
        tbl[18] = mk(0,0,0,  0,0,0,0,     0,1,0, 0,12'h000,0,0);
        tbl[19] = mk(0,0,0,  0,0,0,0,     1,1,2, 0,12'h000,0,1);
        tbl[20] = mk(0,0,0,  0,0,0,0,     1,0,0, 0,12'h000,0,1);
        tbl[21] = mk(0,0,0,  0,0,0,0,     1,0,0, 0,12'h000,0,0);

        // Reset state
        Reset_n = 0;
        cycle();
        cycle();
        check("reset out_valid", out_valid, 0);
        check("reset rgb", {out_red, out_green, out_blue}, 0);
        check("reset flash_active", flash_active, 0);
        Reset_n = 1;

        // Directed vectors
        for (int i = 0; i < 22; i++) begin
            pix_valid = tbl[i].v; pix_pal = tbl[i].pal; pix_idx = tbl[i].idx;
            wr_en = tbl[i].we; wr_pal = tbl[i].wpal; wr_idx = tbl[i].widx; wr_rgb = tbl[i].wrgb;
            frame_tick = tbl[i].tick; flash_start = tbl[i].fs; flash_len = tbl[i].flen;
            cycle();
            check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
            check($sformatf("vec%0d rgb", i), {out_red, out_green, out_blue}, tbl[i].ergb);
            check($sformatf("vec%0d out_transparent", i), out_transparent, tbl[i].et);
            check($sformatf("vec%0d flash_active", i), flash_active, tbl[i].ea);
        end

        // Reset asserted mid-flash with the pipeline full
        idle_inputs();
        flash_start = 1; flash_len = 4'd5;
        wr_en = 1; wr_pal = 2'd3; wr_idx = 4'd7; wr_rgb = 12'h321;
        pix_valid = 1; pix_pal = 2'd1; pix_idx = 4'd9;
        cycle();
        idle_inputs();
        pix_valid = 1; pix_pal = 2'd3; pix_idx = 4'd7;
        cycle();
        check("midflash pre-reset flash_active", flash_active, 1);
        Reset_n = 0;
        cycle();
        check("reset mid-flash out_valid", out_valid, 0);
        check("reset mid-flash flash_active", flash_active, 0);
        check("reset mid-flash rgb", {out_red, out_green, out_blue}, 0);
        Reset_n = 1;
        cycle();
        idle_inputs();
        cycle();
        check("post-reset palette restored", {out_red, out_green, out_blue}, 12'h0FF);
        check("post-reset out_valid", out_valid, 1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            Reset_n     = ($urandom_range(0, 199) != 0);
            pix_valid   = ($urandom_range(0, 3) != 0);
            pix_pal     = 2'($urandom_range(0, 3));
            pix_idx     = 4'($urandom_range(0, 15));
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_pal      = 2'($urandom_range(0, 3));
            wr_idx      = 4'($urandom_range(0, 15));
            wr_rgb      = 12'($urandom);
            frame_tick  = ($urandom_range(0, 7) == 0);
            flash_start = ($urandom_range(0, 39) == 0);
            flash_len   = 4'($urandom_range(0, 6));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
